axi_mm2s_rd_slave: RTL and testbench



---
 rtl/axi_mm2s_rd_slave.sv | 178 +++++++++++++++++
 tb/tb_axi_mm2s_rd_slave.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mm2s_rd_slave.sv
// AXI4 read-only responder for the DMA MM2S port: returns an address-derived
// XOR pattern with one active and one pending burst and RLAST framing.
module axi_mm2s_rd_slave #(
  parameter logic [31:0] PATTERN_SEED = 32'h5A5A_5A5A,
  parameter logic [31:0] MEM_BASE     = 32'h0000_0000,
  parameter logic [31:0] MEM_SIZE     = 32'h0001_0000,
  parameter int unsigned STALL_EVERY  = 0
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic [1:0]  S_AXI_ARBURST,
  input  logic [7:0]  S_AXI_ARLEN,
  input  logic [2:0]  S_AXI_ARSIZE,
  input  logic [3:0]  S_AXI_ARCACHE,
  input  logic [2:0]  S_AXI_ARPROT,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RLAST,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic        CLR_STATS,
  output logic [15:0] BURST_CNT,
  output logic        ERR_FLAG
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLV  = 2'b10;
  localparam logic [1:0] RESP_DEC  = 2'b11;

  typedef struct packed {
    logic [29:0] waddr;
    logic [7:0]  len;
    logic        fixed;
    logic [1:0]  resp;
  } burst_t;

  state_t      state_q, state_d;
  burst_t      act_q, act_d, pend_q, pend_d, ar_req;
  logic        pend_vld_q, pend_vld_d;
  logic [7:0]  beat_q, beat_d;
  logic [31:0] stall_q, stall_d;
  logic        rvalid_q, rvalid_d;
  logic        arready_q;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        ar_hs, xfer, last_beat;
  logic [31:0] ar_off;
  logic        unused;

  assign unused    = ^{S_AXI_ARCACHE, S_AXI_ARPROT};
  assign ar_hs     = S_AXI_ARVALID & arready_q;
  assign xfer      = rvalid_q & S_AXI_RREADY;
  assign last_beat = (beat_q == act_q.len);

  // Offset compare wraps addresses below MEM_BASE to large values, so one test covers both bounds.
  always_comb begin
    ar_off       = S_AXI_ARADDR - MEM_BASE;
    ar_req.waddr = S_AXI_ARADDR[31:2];
    ar_req.len   = S_AXI_ARLEN;
    ar_req.fixed = (S_AXI_ARBURST == 2'b00);
    if (S_AXI_ARSIZE != 3'b010 || S_AXI_ARBURST[1])
      ar_req.resp = RESP_SLV;
    else if (ar_off >= MEM_SIZE)
      ar_req.resp = RESP_DEC;
    else
      ar_req.resp = RESP_OKAY;
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q    <= IDLE;
      act_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      beat_q     <= '0;
      stall_q    <= '0;
      rvalid_q   <= 1'b0;
      arready_q  <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      beat_q     <= beat_d;
      stall_q    <= stall_d;
      rvalid_q   <= rvalid_d;
      arready_q  <= !pend_vld_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    act_d      = act_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    beat_d     = beat_q;
    stall_d    = stall_q;
    rvalid_d   = rvalid_q;
    unique case (state_q)
      IDLE: begin
        if (ar_hs) begin
          state_d  = BURST;
          act_d    = ar_req;
          beat_d   = '0;
          stall_d  = '0;
          rvalid_d = 1'b1;
        end
      end
      BURST: begin
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
        end else if (xfer && last_beat) begin
          beat_d  = '0;
          stall_d = '0;
          if (pend_vld_q) begin
            act_d      = pend_q;
            pend_vld_d = 1'b0;
          end else if (ar_hs) begin
            act_d = ar_req;
          end else begin
            state_d  = IDLE;
            rvalid_d = 1'b0;
          end
        end else if (xfer) begin
          beat_d = beat_q + 8'd1;
          if (!act_q.fixed)
            act_d.waddr = act_q.waddr + 30'd1;
          if (STALL_EVERY != 0 && stall_q + 32'd1 == STALL_EVERY) begin
            stall_d  = '0;
            rvalid_d = 1'b0;
          end else begin
            stall_d = stall_q + 32'd1;
          end
        end
        // An AR arriving on the final beat with no pending entry was loaded straight into active above.
        if (ar_hs && !(xfer && last_beat)) begin
          pend_d     = ar_req;
          pend_vld_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (CLR_STATS) begin
      cnt_d = '0;
      err_d = 1'b0;
    end else begin
      if (xfer && last_beat)
        cnt_d = cnt_q + 16'd1;
      if (xfer && act_q.resp != RESP_OKAY)
        err_d = 1'b1;
    end
  end

  always_comb begin
    S_AXI_ARREADY = arready_q;
    S_AXI_RVALID  = rvalid_q;
    S_AXI_RLAST   = rvalid_q & last_beat;
    S_AXI_RRESP   = rvalid_q ? act_q.resp : RESP_OKAY;
    S_AXI_RDATA   = (rvalid_q && act_q.resp == RESP_OKAY) ?
                    ({act_q.waddr, 2'b00} ^ PATTERN_SEED) : '0;
    BURST_CNT     = cnt_q;
    ERR_FLAG      = err_q;
  end

endmodule

// File: tb/tb_axi_mm2s_rd_slave.sv
// Directed bench for axi_mm2s_rd_slave: expected beats are queued when an AR is
// issued and popped by negedge monitors as the slaves deliver them.
module tb_axi_mm2s_rd_slave;

  localparam logic [31:0] SEED = 32'h5A5A_5A5A;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [31:0] SIZE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] araddr;
  logic [1:0]  arburst;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        arvalid, arvalid_s, rready, clr, toggle;

  logic        arready, rvalid, rlast, err;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [15:0] cnt;
  logic        arready_s, rvalid_s, rlast_s, err_s;
  logic [31:0] rdata_s;
  logic [1:0]  rresp_s;
  logic [15:0] cnt_s;

  int n_chk = 0;
  int n_err = 0;
  logic [34:0] q[$];
  logic [34:0] qs[$];

  always #5 clk = ~clk;

  axi_mm2s_rd_slave #(.PATTERN_SEED(SEED), .MEM_BASE(BASE), .MEM_SIZE(SIZE), .STALL_EVERY(0)) u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .S_AXI_ARADDR(araddr), .S_AXI_ARBURST(arburst),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARCACHE(4'h3), .S_AXI_ARPROT(3'h0),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready), .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RLAST(rlast), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready), .CLR_STATS(clr),
    .BURST_CNT(cnt), .ERR_FLAG(err));

  axi_mm2s_rd_slave #(.PATTERN_SEED(SEED), .MEM_BASE(BASE), .MEM_SIZE(SIZE), .STALL_EVERY(2)) u_dut_stall (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .S_AXI_ARADDR(araddr), .S_AXI_ARBURST(arburst),
    .S_AXI_ARLEN(arlen), .S_AXI_ARSIZE(arsize), .S_AXI_ARCACHE(4'h0), .S_AXI_ARPROT(3'h0),
    .S_AXI_ARVALID(arvalid_s), .S_AXI_ARREADY(arready_s), .S_AXI_RDATA(rdata_s), .S_AXI_RRESP(rresp_s),
    .S_AXI_RLAST(rlast_s), .S_AXI_RVALID(rvalid_s), .S_AXI_RREADY(rready), .CLR_STATS(clr),
    .BURST_CNT(cnt_s), .ERR_FLAG(err_s));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit sel);
    logic [1:0]  resp;
    logic [31:0] a, d;
    if (size != 3'b010 || burst == 2'b10 || burst == 2'b11) resp = 2'b10;
    else if (addr < BASE || addr >= BASE + SIZE) resp = 2'b11;
    else resp = 2'b00;
    for (int i = 0; i <= int'(len); i++) begin
      a = (burst == 2'b00) ? addr : addr + 32'(4 * i);
      d = (resp == 2'b00) ? ((a & 32'hFFFF_FFFC) ^ SEED) : 32'h0;
      if (sel) qs.push_back({d, resp, i == int'(len)});
      else     q.push_back({d, resp, i == int'(len)});
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the AR handshake edge.
  task automatic ar_issue(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input bit sel);
    int n = 0;
    araddr = addr; arlen = len; arsize = size; arburst = burst;
    if (sel) arvalid_s = 1'b1; else arvalid = 1'b1;
    push_exp(addr, len, size, burst, sel);
    while (!(sel ? arready_s : arready) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk(sel ? "arready_s" : "arready", sel ? arready_s : arready, 1);
    @(posedge clk); #1;
    arvalid = 1'b0; arvalid_s = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      if (toggle) rready = ~rready;
      n++;
    end
    chk("drain", q.size(), 0);
    rready = 1'b1;
  endtask

  logic [35:0] held_v;
  bit          held = 0;
  logic [34:0] e, es;

  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
    end else begin
      if (held) chk("hold_stable", {rvalid, rdata, rresp, rlast}, held_v);
      held   = rvalid && !rready;
      held_v = {rvalid, rdata, rresp, rlast};
      if (rvalid && rready) begin
        if (q.size() == 0) chk("beat_unexpected", rvalid, 0);
        else begin
          e = q.pop_front();
          chk("beat", {rdata, rresp, rlast}, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rvalid_s && rready) begin
      if (qs.size() == 0) chk("beat_s_unexpected", rvalid_s, 0);
      else begin
        es = qs.pop_front();
        chk("beat_s", {rdata_s, rresp_s, rlast_s}, es);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pat[9] = '{1, 1, 0, 1, 1, 0, 1, 1, 0};
    araddr = '0; arburst = 2'b01; arlen = '0; arsize = 3'b010;
    arvalid = 1'b0; arvalid_s = 1'b0; rready = 1'b0; clr = 1'b0; toggle = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_outputs", {arready, rvalid, rlast, rdata, rresp}, '0);
    chk("rst_stats", {cnt, err}, '0);
    repeat (2) @(posedge clk);
    #1 chk("rst_arready_held", arready, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_rst", arready, 1);

    // Single INCR burst at 0x100
    rready = 1'b1;
    ar_issue(32'h100, 8'd3, 3'b010, 2'b01, 0);
    chk("rvalid_latency", rvalid, 1);
    drain(50);
    chk("burst_cnt_1", cnt, 1);
    chk("err_clean", err, 0);

    // Back-to-back bursts via the pending register
    ar_issue(32'h200, 8'd1, 3'b010, 2'b01, 0);
    ar_issue(32'h300, 8'd1, 3'b010, 2'b01, 0);
    chk("pend_full_arready", arready, 0);
    chk("b2b_rvalid0", rvalid, 1);
    @(posedge clk); #1;
    chk("b2b_rvalid1", rvalid, 1);
    chk("arready_reopen", arready, 1);
    @(posedge clk); #1;
    chk("b2b_rvalid2", rvalid, 1);
    @(posedge clk); #1;
    chk("b2b_idle", rvalid, 0);
    chk("b2b_queue", q.size(), 0);

    // RREADY toggling during an 8-beat burst
    toggle = 1'b1;
    ar_issue(32'h400, 8'd7, 3'b010, 2'b01, 0);
    drain(100);
    toggle = 1'b0;
    chk("burst_cnt_4", cnt, 4);

    // Error and boundary bursts
    ar_issue(32'h500, 8'd2, 3'b001, 2'b01, 0);
    drain(50);
    chk("err_after_slverr", err, 1);
    ar_issue(BASE + SIZE, 8'd0, 3'b010, 2'b01, 0);
    drain(50);
    ar_issue(32'h40, 8'd1, 3'b010, 2'b10, 0);
    drain(50);
    ar_issue(32'h604, 8'd2, 3'b010, 2'b00, 0);
    drain(50);
    ar_issue(BASE + SIZE - 32'd4, 8'd1, 3'b010, 2'b01, 0);
    drain(50);
    chk("burst_cnt_9", cnt, 9);

    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_stats", {cnt, err}, 17'h0);

    // Clear coincident with a last-beat error transfer
    rready = 1'b0;
    ar_issue(32'h0002_0000, 8'd0, 3'b010, 2'b01, 0);
    rready = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_wins", {cnt, err}, 17'h0);
    chk("clr_wins_queue", q.size(), 0);

    // Periodic RVALID gaps on the STALL_EVERY=2 instance
    ar_issue(32'h900, 8'd5, 3'b010, 2'b01, 1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      chk("stall_pattern", rvalid_s, pat[i]);
    end
    chk("stall_queue", qs.size(), 0);
    chk("stall_cnt", cnt_s, 1);

    // Reset in the middle of a burst
    ar_issue(32'h700, 8'd7, 3'b010, 2'b01, 0);
    repeat (2) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_outputs", {arready, rvalid, rlast, rdata, rresp}, '0);
    chk("mid_rst_stats", {cnt, err}, '0);
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_mid_rst", arready, 1);
    ar_issue(32'h800, 8'd0, 3'b010, 2'b01, 0);
    drain(50);
    chk("post_rst_cnt", cnt, 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
